// File: rtl/pla_tt_pkg.sv
// Shared types and sizing helpers for the PLA truth-table sweeper.
package pla_tt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of truth-table entries for an n-input function.
    function automatic int tt_width(input int n);
        return 2 ** n;
    endfunction

    // A full-ones table of 2**n entries needs n+1 bits to count.
    function automatic int ones_width(input int n);
        return n + 1;
    endfunction

    localparam int PLA_N_IN   = 6;
    localparam int PLA_ONES_W = ones_width(PLA_N_IN);

endpackage

// File: rtl/pla_tt_tagpipe.sv
// LATENCY-deep valid+index delay line that lines each captured y_in up with
// the index that produced it. Collapses to plain wires when LATENCY is 0.
module pla_tt_tagpipe #(
    parameter int LATENCY = 0,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             pending
);

    if (LATENCY == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, flush};
        assign out_vld    = in_vld;
        assign out_idx    = in_idx;
        assign pending    = 1'b0;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_p;
        logic [IDX_W-1:0]   idx_p [LATENCY];

        // Valid bits: the only state here that needs reset and flush.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= '0;
            end else if (flush) begin
                vld_p <= '0;
            end else begin
                for (int i = LATENCY - 1; i > 0; i--) begin
                    vld_p[i] <= vld_p[i-1];
                end
                vld_p[0] <= in_vld;
            end
        end

        // Index tags ride alongside; only meaningful where vld_p is set.
        always_ff @(posedge clk) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                idx_p[i] <= idx_p[i-1];
            end
            idx_p[0] <= in_idx;
        end

        // Entries still in flight ahead of the output stage.
        always_comb begin
            pending = 1'b0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                pending = pending | vld_p[i];
            end
        end

        assign out_vld = vld_p[LATENCY-1];
        assign out_idx = idx_p[LATENCY-1];
    end

endmodule

// File: rtl/pla_tt_sweeper.sv
// Sweeps all 2**N_IN input vectors through an external function block,
// captures its truth table, counts ones and compares against EXPECTED.
// Optional build macro PLA_FIRST_MISMATCH_EN adds mm_idx/mm_vld, which
// latch the index of the first sample that differs from EXPECTED.
module pla_tt_sweeper
    import pla_tt_pkg::*;
#(
    parameter int                          N_IN     = PLA_N_IN,
    parameter int                          LATENCY  = 0,
    parameter logic [tt_width(N_IN)-1:0]   EXPECTED = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic [N_IN-1:0]                x_out,
    input  logic                           y_in,
    output logic                           busy,
    output logic                           done,
    output logic [tt_width(N_IN)-1:0]      tt,
    output logic [ones_width(N_IN)-1:0]    ones_count,
    output logic                           match,
    output logic                           done_seen
`ifdef PLA_FIRST_MISMATCH_EN
    ,
    output logic [N_IN-1:0]                mm_idx,
    output logic                           mm_vld
`endif
);

    localparam int              TT_W    = tt_width(N_IN);
    localparam int              ONES_W  = ones_width(N_IN);
    localparam logic [N_IN:0]   IDX_END = (N_IN + 1)'(TT_W);
    localparam logic [N_IN:0]   IDX_ONE = (N_IN + 1)'(1);
    localparam logic [ONES_W-1:0] CNT_ONE = ONES_W'(1);

    state_t              state_q, state_d;
    logic [N_IN:0]       idx_q;      // next index to issue; extra bit marks the end
    logic                accept, stop, issue;
    logic                tap_vld, pending, wr;
    logic [N_IN-1:0]     tap_idx;
    logic [TT_W-1:0]     tt_d;
    logic [ONES_W-1:0]   ones_d;

    assign accept = start && !abort && (state_q == IDLE || state_q == DONE);
    assign stop   = abort && (state_q == SWEEP || state_q == DRAIN);
    assign issue  = (state_q == SWEEP);
    assign wr     = tap_vld && !stop;

    pla_tt_tagpipe #(
        .LATENCY (LATENCY),
        .IDX_W   (N_IN)
    ) u_tagpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (stop),
        .in_vld  (issue),
        .in_idx  (x_out),
        .out_vld (tap_vld),
        .out_idx (tap_idx),
        .pending (pending)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (abort)                 state_d = IDLE;
                else if (idx_q == IDX_END) state_d = (LATENCY == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (abort)        state_d = IDLE;
                else if (!pending) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = accept ? SWEEP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Index issue: x_out steps once per SWEEP cycle and holds after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            x_out <= '0;
        end else if (accept) begin
            idx_q <= IDX_ONE;
            x_out <= '0;
        end else if (issue && !abort && idx_q != IDX_END) begin
            idx_q <= idx_q + IDX_ONE;
            x_out <= idx_q[N_IN-1:0];
        end
    end

    // Next table/count: cleared on an accepted start, else written from the tap.
    always_comb begin
        tt_d   = tt;
        ones_d = ones_count;
        if (accept) begin
            tt_d   = '0;
            ones_d = '0;
        end else if (wr) begin
            tt_d[tap_idx] = y_in;
            if (y_in) ones_d = ones_count + CNT_ONE;
        end
    end

    // Result registers; match is taken from the next table so it is ready in the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt         <= '0;
            ones_count <= '0;
            match      <= 1'b0;
            done_seen  <= 1'b0;
        end else begin
            tt         <= tt_d;
            ones_count <= ones_d;
            match      <= (tt_d == EXPECTED);
            if (accept || stop)      done_seen <= 1'b0;
            else if (state_d == DONE) done_seen <= 1'b1;
        end
    end

`ifdef PLA_FIRST_MISMATCH_EN
    // First-mismatch capture; later mismatches leave the latched index alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_idx <= '0;
            mm_vld <= 1'b0;
        end else if (accept) begin
            mm_idx <= '0;
            mm_vld <= 1'b0;
        end else if (wr && !mm_vld && (y_in != EXPECTED[tap_idx])) begin
            mm_idx <= tap_idx;
            mm_vld <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pla_tt_sweeper.sv
// Directed bench for pla_tt_sweeper: three instances (combinational function
// with two golden tables, and a 2-cycle-latency function) share start/abort.
module tb_pla_tt_sweeper;

    localparam int OW = pla_tt_pkg::PLA_ONES_W;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic [1:0] mode;

    logic [5:0]    x_a, x_b, x_c;
    logic          y_a, y_b, y_c;
    logic          busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [63:0]   tt_a, tt_b, tt_c;
    logic [OW-1:0] ones_a, ones_b, ones_c;
    logic          match_a, match_b, match_c, ds_a, ds_b, ds_c;
`ifdef PLA_FIRST_MISMATCH_EN
    logic [5:0]    mmi_a, mmi_b, mmi_c;
    logic          mmv_a, mmv_b, mmv_c;
`endif
    logic          d1, d2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Function under test for the combinational instances, selected by mode.
    function automatic logic y_of(input logic [1:0] m, input logic [5:0] x);
        case (m)
            2'd0:    return 1'b0;
            2'd1:    return x[0];
            2'd2:    return 1'b1;
            default: return (x == 6'd37);
        endcase
    endfunction

    assign y_a = y_of(mode, x_a);
    assign y_b = y_of(mode, x_b);

    // y = x5 delayed two cycles for the latency instance.
    always_ff @(posedge clk) begin
        d1 <= x_c[5];
        d2 <= d1;
    end
    assign y_c = d2;

    pla_tt_sweeper #(.N_IN(6), .LATENCY(0), .EXPECTED(64'h0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_out(x_a), .y_in(y_a),
        .busy(busy_a), .done(done_a), .tt(tt_a), .ones_count(ones_a), .match(match_a),
        .done_seen(ds_a)
`ifdef PLA_FIRST_MISMATCH_EN
        , .mm_idx(mmi_a), .mm_vld(mmv_a)
`endif
    );

    pla_tt_sweeper #(.N_IN(6), .LATENCY(0), .EXPECTED(64'hAAAA_AAAA_AAAA_AAAA)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_out(x_b), .y_in(y_b),
        .busy(busy_b), .done(done_b), .tt(tt_b), .ones_count(ones_b), .match(match_b),
        .done_seen(ds_b)
`ifdef PLA_FIRST_MISMATCH_EN
        , .mm_idx(mmi_b), .mm_vld(mmv_b)
`endif
    );

    pla_tt_sweeper #(.N_IN(6), .LATENCY(2), .EXPECTED(64'hFFFF_FFFF_0000_0000)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_out(x_c), .y_in(y_c),
        .busy(busy_c), .done(done_c), .tt(tt_c), .ones_count(ones_c), .match(match_c),
        .done_seen(ds_c)
`ifdef PLA_FIRST_MISMATCH_EN
        , .mm_idx(mmi_c), .mm_vld(mmv_c)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Pulse start in cycle 0, then watch `budget` cycles; optional start/abort at given cycles.
    task automatic run_sweep(input int restart_at, input int abort_at, input int budget,
                             output int da, output int dc, output int na);
        da = -1; dc = -1; na = 0;
        start = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); #1;
            start = (c == restart_at);
            abort = (c == abort_at);
            if (c == 1) chk("busy_rise", busy_a, 1);
            if (abort_at > 0 && c == abort_at + 1) chk("busy_after_abort", busy_a, 0);
            if (done_a) begin
                if (da < 0) chk("busy_low_at_done", busy_a, 0);
                if (da < 0) da = c;
                na++;
            end
            if (done_c && dc < 0) dc = c;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] tt;
        int          ones;
        logic        m_a;
        logic        m_b;
        logic        mmv;
        int          mmi;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int da, dc, na, n;

        vecs[0] = '{mode: 2'd0, tt: 64'h0,                   ones: 0,  m_a: 1'b1, m_b: 1'b0, mmv: 1'b0, mmi: 0};
        vecs[1] = '{mode: 2'd1, tt: 64'hAAAA_AAAA_AAAA_AAAA, ones: 32, m_a: 1'b0, m_b: 1'b1, mmv: 1'b1, mmi: 1};
        vecs[2] = '{mode: 2'd2, tt: 64'hFFFF_FFFF_FFFF_FFFF, ones: 64, m_a: 1'b0, m_b: 1'b0, mmv: 1'b1, mmi: 0};
        vecs[3] = '{mode: 2'd3, tt: 64'h0000_0020_0000_0000, ones: 1,  m_a: 1'b0, m_b: 1'b0, mmv: 1'b1, mmi: 37};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", x_a, 0);
        chk("rst_tt", tt_a, 0);
        chk("rst_ones", ones_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_match", match_a, 0);
        chk("rst_done_seen", ds_a, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sweeps over the vector table.
        for (int i = 0; i < 4; i++) begin
            mode = vecs[i].mode;
            run_sweep(-1, -1, 70, da, dc, na);
            chk("v_done_cycle", 64'(da), 64'd65);
            chk("v_done_pulses", 64'(na), 64'd1);
            chk("v_tt_a", tt_a, vecs[i].tt);
            chk("v_tt_b", tt_b, vecs[i].tt);
            chk("v_ones_a", ones_a, 64'(vecs[i].ones));
            chk("v_match_a", match_a, vecs[i].m_a);
            chk("v_match_b", match_b, vecs[i].m_b);
            chk("v_done_seen", ds_a, 1);
            chk("v_lat_done_cycle", 64'(dc), 64'd67);
            chk("v_lat_tt", tt_c, 64'hFFFF_FFFF_0000_0000);
            chk("v_lat_ones", ones_c, 32);
            chk("v_lat_match", match_c, 1);
`ifdef PLA_FIRST_MISMATCH_EN
            chk("v_mm_vld", mmv_a, vecs[i].mmv);
            if (vecs[i].mmv) chk("v_mm_idx", mmi_a, 64'(vecs[i].mmi));
            chk("v_mm_vld_b", mmv_b, (vecs[i].mode != 2'd1));
`endif
        end

        // start mid-sweep is ignored.
        mode = 2'd1;
        run_sweep(20, -1, 70, da, dc, na);
        chk("restart_done_cycle", 64'(da), 64'd65);
        chk("restart_done_pulses", 64'(na), 64'd1);
        chk("restart_tt", tt_b, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("restart_ones", ones_b, 32);

        // abort during cycle 11 with y=1: indices 0..9 kept, no done.
        mode = 2'd2;
        run_sweep(-1, 11, 80, da, dc, na);
        chk("abort_no_done", (da < 0), 1);
        chk("abort_ones", ones_a, 10);
        chk("abort_tt", tt_a, 64'h3FF);
        chk("abort_done_seen", ds_a, 0);
        chk("abort_busy", busy_a, 0);

        // start in the done cycle begins a new sweep.
        mode = 2'd1;
        start = 1'b1;
        n = 0;
        for (int c = 1; c <= 80 && n == 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_a) n = c;
        end
        chk("b2b_first_done", 64'(n), 64'd65);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", busy_a, 1);
        chk("b2b_x0", x_a, 0);
        chk("b2b_done_seen_clr", ds_a, 0);
        n = 1;
        while (!done_a && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_done", 64'(n), 64'd65);
        chk("b2b_tt", tt_b, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("b2b_match", match_b, 1);

        // start and abort together while idle: abort wins.
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy_a, 0);
        @(posedge clk); #1;
        chk("start_abort_busy2", busy_a, 0);

        // Asynchronous reset in the middle of a sweep.
        mode = 2'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #3;
        chk("pre_rst_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_x", x_a, 0);
        chk("arst_tt", tt_a, 0);
        chk("arst_ones", ones_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_busy_c", busy_c, 0);
        chk("arst_done", done_a, 0);
        chk("arst_match", match_a, 0);
        chk("arst_done_seen", ds_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy_a, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pla_tt_sweeper.md
Name: pla_tt_sweeper

Overview:
- Sequential test harness stage for 6-input PLA-derived combinational functions.
- Drives every input vector onto a downstream function block (x0..x5) and consumes its single output (y0).
- Assembles the full truth table, a ones count and a pass/fail against an expected table.
- Used to characterise and regress optimised PLA netlists in silicon or on FPGA.

Parameters:
- N_IN, 6: number of function inputs; the table has 2**N_IN entries.
- LATENCY, 0: cycles from an x_out change to the matching y_in being valid (0 = purely combinational DUT).
- EXPECTED, 64'h0: golden truth table; bit i is the expected y for input index i.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep
- abort  in  1  cancel the sweep in progress
- x_out  out  N_IN  input vector to the function; x_out[0]=x0 … x_out[5]=x5
- y_in  in  1  function output y0
- busy  out  1  high from the cycle after start is accepted until the cycle done is asserted
- done  out  1  one-cycle pulse when the table is complete
- tt  out  2**N_IN  captured truth table; bit i = y for index i
- ones_count  out  N_IN+1  number of 1 bits in tt
- match  out  1  tt == EXPECTED; valid while done_seen=1
- done_seen  out  1  sticky; set with done, cleared by start or abort

Behaviour:
- Clock and reset:
  - Single clock clk. Reset rst_n is asynchronous and active-low.
  - All outputs and state are 0 under reset (x_out=0, tt=0, ones_count=0, busy=0, done=0, match=0, done_seen=0).
  - State returns to IDLE immediately on reset assertion, including mid-sweep.
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - A start sampled at clock edge k moves to SWEEP.
  - On that edge: idx=0, tt=0, ones_count=0, done_seen=0.
- SWEEP:
  - x_out = idx, registered.
  - Index i is presented during cycle k+1+i.
  - idx increments every cycle. After index 2**N_IN-1 is issued, go to DRAIN; if LATENCY=0, go straight to DONE.
- Sample alignment:
  - A valid/index tag shift register of depth LATENCY tracks each issued index.
  - y_in for index i is written into tt[i] at the edge closing cycle k+1+i+LATENCY.
  - ones_count increments on the same edge when y_in=1.
- DRAIN:
  - x_out holds its last value.
  - Stay until the tag pipe is empty, then go to DONE.
- DONE:
  - done=1 for exactly one cycle: cycle k+2**N_IN+LATENCY+1.
  - busy falls in that same cycle; done_seen is set; then return to IDLE.
- match: a registered compare of tt against EXPECTED, evaluated so it is valid in the done cycle.
- start while busy: ignored, with no effect on idx or tt.
- start in the DONE cycle: accepted, begins a new sweep.
- abort:
  - Honoured in SWEEP or DRAIN; return to IDLE on the next edge.
  - busy=0, done not pulsed, done_seen=0, tag pipe flushed.
  - tt and ones_count keep their partial contents.
- start and abort in the same cycle: abort wins.
- Wrap: idx is N_IN+1 bits internally, so terminal detection never aliases to 0.
- Outputs after completion: tt and ones_count hold until the next accepted start.

Optional Feature:
- Macro: PLA_FIRST_MISMATCH_EN.
- Defined: adds ports mm_idx (out, N_IN) and mm_vld (out, 1).
  - On the first sample where y_in != EXPECTED[i], latch mm_idx=i and set mm_vld.
  - Later mismatches are ignored. Both are cleared by an accepted start and by reset.
  - If there is no mismatch, mm_vld=0 at done.
- Undefined: neither port exists, and no compare logic beyond match is built.

Decomposition:
- Package pla_tt_pkg:
  - FSM state enum (IDLE, SWEEP, DRAIN, DONE).
  - Function tt_width(n) = 2**n.
  - Localparam for the ones_count width.
- One sub-module, pla_tt_tagpipe: LATENCY-deep valid+index delay line with flush.
  - Degenerates to wires when LATENCY=0.

Test Plan:
- y_in tied 0, EXPECTED=0, start at cycle 0 → done in cycle 65, tt=64'h0, ones_count=0, match=1.
- y_in = x_out[0] combinationally, EXPECTED=64'hAAAA_AAAA_AAAA_AAAA → tt equals it, ones_count=32, match=1.
- LATENCY=2, DUT model y = x5 delayed 2 cycles → tt=64'hFFFF_FFFF_0000_0000, ones_count=32, done in cycle 67.
- start pulsed again at cycle 20 of a sweep → ignored; done still at cycle 65 with an unchanged tt.
- abort at cycle 11 (indices 0..9 captured with y=1) → busy=0 next cycle, no done, ones_count=10, done_seen=0.
- Coverage points:
  - rst_n low mid-sweep → all outputs 0 asynchronously.
  - With PLA_FIRST_MISMATCH_EN, y_in=1 only at index 37 and EXPECTED=0 → mm_vld=1, mm_idx=37, match=0.
